// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the JTAG memory loader.
package loader_pkg;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int CW    = AW + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_D = 2'd1,
    LOAD_I = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/jtag_mem_loader_if.sv
// Data/instruction memory port bundle driven by the loader (master) and served by the memories (slave).
interface jtag_mem_loader_if;
  import loader_pkg::*;

  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic [DW-1:0] imem_rdata;

  modport master (
    output dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata,
    output imem_we, imem_addr, imem_wdata,
    input  imem_rdata
  );

  modport slave (
    input  dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata,
    input  imem_we, imem_addr, imem_wdata,
    output imem_rdata
  );

endinterface

// File: rtl/jtag_mem_loader.sv
// Serial boot loader: streams data then instruction images, highest address first,
// returns the displaced word and holds the core until both images are in place.
module jtag_mem_loader
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Jen,
  input  logic [DW-1:0]        Jin,
  output logic [DW-1:0]        Jout,
  jtag_mem_loader_if.master    mem,
  output logic                 core_hold,
  output logic                 load_done,
  output logic [AW+1:0]        word_cnt
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] r_jout;
  logic          w_d_we;
  logic          w_i_we;
  logic [AW-1:0] w_d_addr;
  logic [AW-1:0] w_i_addr;

  // Next-state, counter and write-port decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_d_we      = 1'b0;
    w_i_we      = 1'b0;
    w_d_addr    = {AW{1'b0}};
    w_i_addr    = {AW{1'b0}};
    case (r_state)
      IDLE: begin
        if (Jen) begin
          w_d_we      = 1'b1;
          w_d_addr    = AW'(DEPTH - 1);
          w_cnt_nxt   = CW'(1);
          w_state_nxt = LOAD_D;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD_D: begin
        w_d_addr = AW'(DEPTH - 1) - r_cnt[AW-1:0];
        if (Jen) begin
          w_d_we    = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(DEPTH - 1)) begin
            w_state_nxt = LOAD_I;
          end else begin
            w_state_nxt = LOAD_D;
          end
        end else begin
          w_state_nxt = LOAD_D;
        end
      end
      LOAD_I: begin
        // Low address bits of word_cnt already equal word_cnt - DEPTH in this bank
        w_i_addr = AW'(DEPTH - 1) - r_cnt[AW-1:0];
        if (Jen) begin
          w_i_we    = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(2 * DEPTH - 1)) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = LOAD_I;
          end
        end else begin
          w_state_nxt = LOAD_I;
        end
      end
      DONE: begin
        if (Jen) begin
          w_d_we      = 1'b1;
          w_d_addr    = AW'(DEPTH - 1);
          w_cnt_nxt   = CW'(1);
          w_state_nxt = LOAD_D;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // State, word counter and readback register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
      r_jout  <= {DW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (Jen) begin
        r_jout <= w_d_we ? mem.dmem_rdata : mem.imem_rdata;
      end else begin
        r_jout <= r_jout;
      end
    end
  end

  // Reset overrides any write requested in the same cycle
  assign mem.dmem_we    = w_d_we & ~rst;
  assign mem.imem_we    = w_i_we & ~rst;
  assign mem.dmem_addr  = w_d_addr;
  assign mem.imem_addr  = w_i_addr;
  assign mem.dmem_wdata = Jin;
  assign mem.imem_wdata = Jin;

  assign Jout      = r_jout;
  assign word_cnt  = r_cnt;
  assign load_done = (r_state == DONE);
  assign core_hold = (r_state != DONE);

endmodule

// File: tb/tb_jtag_mem_loader.sv
// Directed self-checking bench for jtag_mem_loader with behavioural data/instruction memories.
module tb_jtag_mem_loader;
  import loader_pkg::*;

  logic          clk;
  logic          rst;
  logic          Jen;
  logic [DW-1:0] Jin;
  logic [DW-1:0] Jout;
  logic          core_hold;
  logic          load_done;
  logic [AW+1:0] word_cnt;

  logic [DW-1:0] dmem [DEPTH];
  logic [DW-1:0] imem [DEPTH];
  logic          tb_init;
  logic          tb_pre_we;
  logic [AW-1:0] tb_pre_addr;
  logic [DW-1:0] tb_pre_data;

  int n_checks;
  int n_pass;
  int both_we_cnt;

  jtag_mem_loader_if mif ();

  jtag_mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .Jen       (Jen),
    .Jin       (Jin),
    .Jout      (Jout),
    .mem       (mif),
    .core_hold (core_hold),
    .load_done (load_done),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mif.dmem_rdata = dmem[mif.dmem_addr];
  assign mif.imem_rdata = imem[mif.imem_addr];

  // Single writer process for both memories: fill, preload, DUT writes
  always @(posedge clk) begin
    if (tb_init) begin
      for (int k = 0; k < DEPTH; k++) begin
        dmem[k] <= 32'hD000_0000 | 32'(k);
        imem[k] <= 32'h1000_0000 | 32'(k);
      end
    end else begin
      if (tb_pre_we) dmem[tb_pre_addr] <= tb_pre_data;
      if (mif.dmem_we) dmem[mif.dmem_addr] <= mif.dmem_wdata;
      if (mif.imem_we) imem[mif.imem_addr] <= mif.imem_wdata;
    end
  end

  always @(negedge clk) begin
    if (mif.dmem_we && mif.imem_we) both_we_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Jen = 1'b0;
    Jin = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      Jen = 1'b1;
      Jin = base + 32'(i);
      tick();
    end
    Jen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    Jen = 1'b0;
    Jin = 32'h0;
    tb_init = 1'b1;
    tick();
    tick();
    tb_init = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (word_cnt !== 11'd0) $display("FAIL reset_word_cnt got %0d want 0", word_cnt); else n_pass++;
    n_checks++; if (Jout !== 32'h0) $display("FAIL reset_jout got %h want 0", Jout); else n_pass++;
    n_checks++; if (load_done !== 1'b0) $display("FAIL reset_load_done got %b want 0", load_done); else n_pass++;
    n_checks++; if (core_hold !== 1'b1) $display("FAIL reset_core_hold got %b want 1", core_hold); else n_pass++;
    n_checks++; if ({mif.dmem_we, mif.imem_we} !== 2'b00) $display("FAIL reset_we got %b want 00", {mif.dmem_we, mif.imem_we}); else n_pass++;
    tick();
  endtask

  task automatic test_readback();
    tb_pre_we   = 1'b1;
    tb_pre_addr = 9'd511;
    tb_pre_data = 32'hDEAD_BEEF;
    tick();
    tb_pre_we = 1'b0;
    Jen = 1'b1;
    Jin = 32'h1;
    tick();
    Jen = 1'b0;
    n_checks++; if (dmem[511] !== 32'h1) $display("FAIL rb_dmem511 got %h want 00000001", dmem[511]); else n_pass++;
    n_checks++; if (Jout !== 32'hDEAD_BEEF) $display("FAIL rb_jout got %h want deadbeef", Jout); else n_pass++;
    n_checks++; if (word_cnt !== 11'd1) $display("FAIL rb_word_cnt got %0d want 1", word_cnt); else n_pass++;
  endtask

  task automatic test_full_load();
    int bad_d;
    int bad_i;
    do_reset();
    both_we_cnt = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      Jen = 1'b1;
      Jin = 32'(511 - i);
      @(negedge clk);
      if (i == 511) begin
        n_checks++;
        if ({mif.dmem_we, mif.imem_we, mif.dmem_addr} !== {2'b10, 9'd0})
          $display("FAIL bnd_w511 got we=%b%b addr=%0d want we=10 addr=0", mif.dmem_we, mif.imem_we, mif.dmem_addr);
        else n_pass++;
      end
      if (i == 512) begin
        n_checks++;
        if ({mif.dmem_we, mif.imem_we, mif.imem_addr} !== {2'b01, 9'd511})
          $display("FAIL bnd_w512 got we=%b%b addr=%0d want we=01 addr=511", mif.dmem_we, mif.imem_we, mif.imem_addr);
        else n_pass++;
      end
      if (i == 1023) begin
        n_checks++; if (load_done !== 1'b0) $display("FAIL early_done got %b want 0", load_done); else n_pass++;
      end
      tick();
    end
    Jen = 1'b0;
    n_checks++; if (load_done !== 1'b1) $display("FAIL full_load_done got %b want 1", load_done); else n_pass++;
    n_checks++; if (core_hold !== 1'b0) $display("FAIL full_core_hold got %b want 0", core_hold); else n_pass++;
    n_checks++; if (word_cnt !== 11'd1024) $display("FAIL full_word_cnt got %0d want 1024", word_cnt); else n_pass++;
    n_checks++; if (Jout !== 32'h1000_0000) $display("FAIL full_jout got %h want 10000000", Jout); else n_pass++;
    bad_d = 0;
    bad_i = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (dmem[k] !== 32'(k)) bad_d++;
      if (imem[k] !== 32'(k - 512)) bad_i++;
    end
    n_checks++; if (bad_d != 0) $display("FAIL full_dmem got %0d bad words want 0", bad_d); else n_pass++;
    n_checks++; if (bad_i != 0) $display("FAIL full_imem got %0d bad words want 0", bad_i); else n_pass++;
    n_checks++; if (both_we_cnt != 0) $display("FAIL both_we got %0d cycles want 0", both_we_cnt); else n_pass++;
    tick();
    n_checks++; if (word_cnt !== 11'd1024) $display("FAIL done_saturate got %0d want 1024", word_cnt); else n_pass++;
  endtask

  task automatic test_done_restart();
    @(negedge clk);
    n_checks++;
    if ({mif.dmem_we, mif.imem_we, mif.dmem_addr, mif.imem_addr} !== {2'b00, 9'd0, 9'd0})
      $display("FAIL done_idle got we=%b%b da=%0d ia=%0d want 00 0 0", mif.dmem_we, mif.imem_we, mif.dmem_addr, mif.imem_addr);
    else n_pass++;
    tick();
    Jen = 1'b1;
    Jin = 32'hA5A5_A5A5;
    tick();
    Jen = 1'b0;
    n_checks++; if (dmem[511] !== 32'hA5A5_A5A5) $display("FAIL rs_dmem511 got %h want a5a5a5a5", dmem[511]); else n_pass++;
    n_checks++; if (load_done !== 1'b0) $display("FAIL rs_load_done got %b want 0", load_done); else n_pass++;
    n_checks++; if (core_hold !== 1'b1) $display("FAIL rs_core_hold got %b want 1", core_hold); else n_pass++;
    n_checks++; if (word_cnt !== 11'd1) $display("FAIL rs_word_cnt got %0d want 1", word_cnt); else n_pass++;
    n_checks++; if (Jout !== 32'd511) $display("FAIL rs_jout got %h want 000001ff", Jout); else n_pass++;
  endtask

  task automatic test_pause();
    int we_pulses;
    do_reset();
    send_words(300, 32'h0500_0000);
    we_pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mif.dmem_we || mif.imem_we) we_pulses++;
      tick();
    end
    n_checks++; if (we_pulses != 0) $display("FAIL pause_we got %0d pulses want 0", we_pulses); else n_pass++;
    n_checks++; if (word_cnt !== 11'd300) $display("FAIL pause_word_cnt got %0d want 300", word_cnt); else n_pass++;
    Jen = 1'b1;
    Jin = 32'hC0DE_0300;
    tick();
    Jen = 1'b0;
    n_checks++; if (dmem[211] !== 32'hC0DE_0300) $display("FAIL resume_dmem211 got %h want c0de0300", dmem[211]); else n_pass++;
    n_checks++; if (dmem[212] !== 32'h0500_012B) $display("FAIL pause_dmem212 got %h want 0500012b", dmem[212]); else n_pass++;
    n_checks++; if (word_cnt !== 11'd301) $display("FAIL resume_word_cnt got %0d want 301", word_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_words(700, 32'hAAAA_0000);
    rst = 1'b1;
    Jen = 1'b1;
    Jin = 32'h1234_5678;
    @(negedge clk);
    n_checks++; if ({mif.dmem_we, mif.imem_we} !== 2'b00) $display("FAIL rstmid_we got %b want 00", {mif.dmem_we, mif.imem_we}); else n_pass++;
    tick();
    rst = 1'b0;
    Jen = 1'b0;
    n_checks++; if (word_cnt !== 11'd0) $display("FAIL rstmid_word_cnt got %0d want 0", word_cnt); else n_pass++;
    n_checks++; if (dut.r_state !== IDLE) $display("FAIL rstmid_state got %0d want 0", dut.r_state); else n_pass++;
    n_checks++; if (core_hold !== 1'b1) $display("FAIL rstmid_core_hold got %b want 1", core_hold); else n_pass++;
    n_checks++; if (load_done !== 1'b0) $display("FAIL rstmid_load_done got %b want 0", load_done); else n_pass++;
    n_checks++; if (Jout !== 32'h0) $display("FAIL rstmid_jout got %h want 0", Jout); else n_pass++;
    n_checks++; if (imem[323] !== 32'hFFFF_FF43) $display("FAIL rstmid_imem323 got %h want ffffff43", imem[323]); else n_pass++;
    n_checks++; if (imem[324] !== 32'hAAAA_02BB) $display("FAIL rstmid_imem324 got %h want aaaa02bb", imem[324]); else n_pass++;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    both_we_cnt = 0;
    tb_init     = 1'b0;
    tb_pre_we   = 1'b0;
    tb_pre_addr = 9'd0;
    tb_pre_data = 32'h0;
    rst = 1'b1;
    Jen = 1'b0;
    Jin = 32'h0;
    test_reset();
    test_readback();
    test_full_load();
    test_done_restart();
    test_pause();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
